// File: rtl/pc_sequencer.sv
// Fetch program counter with next-PC selection, write-enable stall, a
// BOOT/RUN/HALT control FSM, misaligned register-target trapping and a retired count.
module pc_sequencer #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pc_wre,
   input  logic [1:0]       pc_src,
   input  logic [WIDTH-1:0] imm,
   input  logic [25:0]      jump_addr,
   input  logic [WIDTH-1:0] reg_target,
   input  logic             halt,
   input  logic             resume,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] pc_next,
   output logic             halted,
   output logic             align_err,
   output logic [CNT_W-1:0] instr_count,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam logic [1:0] SRC_SEQ    = 2'b00;
   localparam logic [1:0] SRC_BRANCH = 2'b01;
   localparam logic [1:0] SRC_JUMP   = 2'b10;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             aerr_q;
   logic [WIDTH-1:0] target;
   logic             misaligned;
   logic             do_update;
   logic             do_trap;
   logic             do_clear;

   assign pc_plus4   = pc_q + WIDTH'(4);
   assign misaligned = (pc_src == 2'b11) && (reg_target[1:0] != 2'b00);

   always_comb begin
      target = reg_target;
      unique case (pc_src)
         SRC_SEQ:    target = pc_plus4;
         SRC_BRANCH: target = pc_plus4 + {imm[WIDTH-3:0], 2'b00};
         SRC_JUMP:   target = {pc_plus4[WIDTH-1:28], jump_addr, 2'b00};
         default:    target = reg_target;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= BOOT;
      else        state_q <= state_d;
   end

   // Next-state logic; halt outranks the stall, which outranks the trap
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (halt)                     state_d = HALT;
            else if (pc_wre && misaligned) state_d = HALT;
         end
         HALT: if (resume && !halt) state_d = RUN;
         default: state_d = BOOT;
      endcase
   end

   // Output / datapath-control decode
   always_comb begin
      do_update = 1'b0;
      do_trap   = 1'b0;
      do_clear  = 1'b0;
      unique case (state_q)
         RUN: begin
            if (!halt && pc_wre) begin
               do_trap   = misaligned;
               do_update = !misaligned;
            end
         end
         HALT:    do_clear = resume && !halt;
         default: ;
      endcase
   end

   assign pc_next = do_update ? target : pc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= RESET_VECTOR;
         cnt_q  <= '0;
         aerr_q <= 1'b0;
      end else begin
         pc_q <= pc_next;
         if (do_update) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         if (do_trap)        aerr_q <= 1'b1;
         else if (do_clear)  aerr_q <= 1'b0;
      end
   end

   assign pc_out      = pc_q;
   assign instr_count = cnt_q;
   assign align_err   = aerr_q;
   assign halted      = (state_q == HALT);
   assign state_dbg   = state_q;

endmodule
